// File: rtl/ga23_sdr_responder_if.sv
// ---------------------------------------------------------------------------
// ga23_sdr_responder_if
//
// Bundles the two request/response channels handled by ga23_sdr_responder.
//
// Layer side (one lane per tile layer, NUM_PORTS lanes):
//   sdr_req   per-port request pulse, one clock wide
//   sdr_addr  per-port 32-bit word address, port p at [p*AW +: AW]
//   sdr_data  per-port returned row, held until the next delivery to that port
//   sdr_rdy   per-port delivery pulse, one clock wide
//
// SDRAM controller side (single shared read channel):
//   mem_req   read request level, held until mem_ack
//   mem_addr  read address, stable while mem_req is high
//   mem_ack   completion pulse; mem_data is valid in the same cycle
//   mem_data  read data
//
// Modports:
//   slave   the responder itself (accepts layer requests, drives the SDRAM read)
//   master  the environment (layers plus SDRAM controller)
// ---------------------------------------------------------------------------
interface ga23_sdr_responder_if #(
  parameter int NUM_PORTS = 3,
  parameter int AW        = 22
) ();

  logic [NUM_PORTS-1:0]    sdr_req;
  logic [NUM_PORTS*AW-1:0] sdr_addr;
  logic [NUM_PORTS*32-1:0] sdr_data;
  logic [NUM_PORTS-1:0]    sdr_rdy;

  logic                    mem_req;
  logic [AW-1:0]           mem_addr;
  logic                    mem_ack;
  logic [31:0]             mem_data;

  modport slave (
    input  sdr_req,
    input  sdr_addr,
    output sdr_data,
    output sdr_rdy,
    output mem_req,
    output mem_addr,
    input  mem_ack,
    input  mem_data
  );

  modport master (
    output sdr_req,
    output sdr_addr,
    input  sdr_data,
    input  sdr_rdy,
    input  mem_req,
    input  mem_addr,
    output mem_ack,
    output mem_data
  );

endinterface

// File: rtl/ga23_sdr_responder.sv
// ---------------------------------------------------------------------------
// ga23_sdr_responder
//
// Memory-side end of the GA23 tile-row fetch interface. Collects one-cycle
// row requests from NUM_PORTS tile layers, serialises them round-robin onto a
// single SDRAM read channel, and returns each 32-bit row to the requesting
// layer together with a one-cycle ready pulse.
//
// Ports:
//   clk        system clock
//   reset_n    asynchronous active-low reset
//   bus        ga23_sdr_responder_if.slave (layer lanes + SDRAM read channel)
//   busy       high while a read is outstanding (ISSUE state)
//   dbg_state  current FSM state (0 = IDLE, 1 = ISSUE)
//   dbg_pend   per-port pending flags
//
// Handshake semantics:
//   Layer side is fire-and-forget: a port raises sdr_req for exactly one clock
//   with sdr_addr valid in that cycle; there is no back-pressure. The request
//   is remembered as pending, and a later request from the same port simply
//   replaces the stored address (latest wins, one slot per port). The answer
//   arrives as a one-clock sdr_rdy with sdr_data valid from that cycle until
//   the next delivery to the same port. A request that is overtaken by a newer
//   one from the same port while its read is in flight is never answered.
//   SDRAM side is a level request: mem_req rises with mem_addr valid and both
//   hold until the controller returns a one-clock mem_ack, in the same cycle
//   as mem_data. mem_ack with no request outstanding is ignored. If reset
//   arrives mid-read, mem_req drops at once and the read is abandoned.
// ---------------------------------------------------------------------------
module ga23_sdr_responder #(
  parameter int NUM_PORTS = 3,
  parameter int AW        = 22
) (
  input  logic                 clk,
  input  logic                 reset_n,
  ga23_sdr_responder_if.slave  bus,
  output logic                 busy,
  output logic [0:0]           dbg_state,
  output logic [NUM_PORTS-1:0] dbg_pend
);

  // Width of a port index; at least one bit so NUM_PORTS=1 still elaborates.
  localparam int PW = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    ISSUE = 1'b1
  } state_t;

  // -------------------------------------------------------------------------
  // State
  // -------------------------------------------------------------------------
  state_t               state_q, state_d;
  logic [NUM_PORTS-1:0] pend_q,  pend_d;      // port has an unserved request
  logic [AW-1:0]        pa_q [NUM_PORTS];     // latest address per port
  logic [AW-1:0]        pa_d [NUM_PORTS];
  logic [PW-1:0]        rr_q,  rr_d;          // round-robin search start
  logic [PW-1:0]        cur_q, cur_d;         // port owning the in-flight read
  logic                 sup_q, sup_d;         // in-flight read has been overtaken
  logic [AW-1:0]        mem_addr_q, mem_addr_d;
  logic [31:0]          data_q [NUM_PORTS];   // last row delivered per port
  logic [31:0]          data_d [NUM_PORTS];
  logic [NUM_PORTS-1:0] rdy_q, rdy_d;

  // -------------------------------------------------------------------------
  // Round-robin arbiter: first pending port at or after rr_q, wrapping.
  // Looks at registered pend only, so a request captured at edge N is first
  // eligible for grant at edge N+1.
  // -------------------------------------------------------------------------
  logic          gnt_vld;
  logic [PW-1:0] gnt;
  logic [PW-1:0] rr_after_gnt;

  always_comb begin
    gnt_vld = 1'b0;
    gnt     = '0;
    for (int i = 0; i < NUM_PORTS; i++) begin
      int j;
      j = int'(rr_q) + i;
      if (j >= NUM_PORTS) begin
        j = j - NUM_PORTS;
      end
      if (!gnt_vld && pend_q[j]) begin
        gnt_vld = 1'b1;
        gnt     = PW'(j);
      end
    end
  end

  assign rr_after_gnt = (gnt == PW'(NUM_PORTS - 1)) ? '0 : gnt + PW'(1);

  // -------------------------------------------------------------------------
  // Next-state and datapath
  // -------------------------------------------------------------------------
  always_comb begin
    // Defaults: hold everything, capture any new requests, no delivery.
    state_d    = state_q;
    pend_d     = pend_q | bus.sdr_req;
    for (int p = 0; p < NUM_PORTS; p++) begin
      pa_d[p] = bus.sdr_req[p] ? bus.sdr_addr[p*AW +: AW] : pa_q[p];
    end
    rr_d       = rr_q;
    cur_d      = cur_q;
    sup_d      = sup_q;
    mem_addr_d = mem_addr_q;
    data_d     = data_q;
    rdy_d      = '0;

    unique case (state_q)
      IDLE: begin
        if (gnt_vld) begin
          state_d    = ISSUE;
          cur_d      = gnt;
          rr_d       = rr_after_gnt;
          // The stored (old) address is issued; a request arriving on the
          // same edge has already been captured into pa_d above.
          mem_addr_d = pa_q[gnt];
          // A same-edge request keeps the port pending and marks the read
          // just issued as already overtaken.
          pend_d[gnt] = bus.sdr_req[gnt];
          sup_d       = bus.sdr_req[gnt];
        end
      end

      ISSUE: begin
        if (bus.sdr_req[cur_q]) begin
          sup_d = 1'b1;
        end
        if (bus.mem_ack) begin
          state_d = IDLE;
          // A request on the ack edge counts as overtaking, so the row is
          // only delivered when neither the flag nor the live request is set.
          if (!sup_q && !bus.sdr_req[cur_q]) begin
            rdy_d[cur_q]  = 1'b1;
            data_d[cur_q] = bus.mem_data;
          end
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // -------------------------------------------------------------------------
  // Registers
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= IDLE;
      pend_q     <= '0;
      rr_q       <= '0;
      cur_q      <= '0;
      sup_q      <= 1'b0;
      mem_addr_q <= '0;
      rdy_q      <= '0;
      for (int p = 0; p < NUM_PORTS; p++) begin
        pa_q[p]   <= '0;
        data_q[p] <= '0;
      end
    end else begin
      state_q    <= state_d;
      pend_q     <= pend_d;
      rr_q       <= rr_d;
      cur_q      <= cur_d;
      sup_q      <= sup_d;
      mem_addr_q <= mem_addr_d;
      rdy_q      <= rdy_d;
      for (int p = 0; p < NUM_PORTS; p++) begin
        pa_q[p]   <= pa_d[p];
        data_q[p] <= data_d[p];
      end
    end
  end

  // -------------------------------------------------------------------------
  // Outputs
  // -------------------------------------------------------------------------
  // mem_req is decoded from the state register so it falls the moment reset
  // clears the state, without waiting for a clock.
  assign bus.mem_req  = (state_q == ISSUE);
  assign bus.mem_addr = mem_addr_q;
  assign bus.sdr_rdy  = rdy_q;

  always_comb begin
    bus.sdr_data = '0;
    for (int p = 0; p < NUM_PORTS; p++) begin
      bus.sdr_data[p*32 +: 32] = data_q[p];
    end
  end

  assign busy      = (state_q == ISSUE);
  assign dbg_state = state_q;
  assign dbg_pend  = pend_q;

endmodule

// File: tb/tb_ga23_sdr_responder.sv
// ---------------------------------------------------------------------------
// tb_ga23_sdr_responder
//
// Self-checking bench for ga23_sdr_responder (NUM_PORTS=3, AW=22).
// Timing within each clock: DUT updates at posedge, monitor samples at +1,
// SDRAM model drives mem_ack/mem_data at +2, main sequence drives and
// samples at +3.
// ---------------------------------------------------------------------------
module tb_ga23_sdr_responder;

  localparam int NP = 3;
  localparam int AW = 22;

  logic          clk;
  logic          reset_n;
  logic          busy;
  logic [0:0]    dbg_state;
  logic [NP-1:0] dbg_pend;

  ga23_sdr_responder_if #(.NUM_PORTS(NP), .AW(AW)) mif ();

  ga23_sdr_responder #(.NUM_PORTS(NP), .AW(AW)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .bus       (mif.slave),
    .busy      (busy),
    .dbg_state (dbg_state),
    .dbg_pend  (dbg_pend)
  );

  // ---------------- clock / reset ----------------
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  // ---------------- scoreboard state ----------------
  int checks = 0;
  int errors = 0;

  logic [33:0]   exp_q[$];        // {port[1:0], data[31:0]} expected deliveries
  logic [AW-1:0] exp_issue_q[$];  // expected mem_addr issue order
  logic [31:0]   rsp_q[$];        // forced read data (else mem_fn)
  int            ack_delay = 0;
  logic          stray_ack = 1'b0;
  logic [NP-1:0] seen_rdy = '0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] mem_fn(input logic [AW-1:0] a);
    return 32'hC0DE_0000 ^ {10'h0, a};
  endfunction

  // ---------------- SDRAM controller model ----------------
  initial begin
    int cnt;
    cnt = 0;
    mif.mem_ack  = 1'b0;
    mif.mem_data = '0;
    forever begin
      @(posedge clk);
      #2;
      if (mif.mem_ack) begin
        mif.mem_ack = 1'b0;
        cnt = 0;
      end else if (stray_ack) begin
        stray_ack    = 1'b0;
        mif.mem_ack  = 1'b1;
        mif.mem_data = 32'hBAD0_0001;
      end else if (reset_n && mif.mem_req) begin
        if (cnt >= ack_delay) begin
          mif.mem_ack  = 1'b1;
          mif.mem_data = (rsp_q.size() > 0) ? rsp_q.pop_front() : mem_fn(mif.mem_addr);
          cnt = 0;
        end else begin
          cnt++;
        end
      end else begin
        cnt = 0;
      end
    end
  end

  // ---------------- monitor / scoreboard ----------------
  initial begin
    logic prev_req;
    logic [AW-1:0] ea;
    logic [33:0] e;
    prev_req = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      if (!reset_n) begin
        prev_req = 1'b0;
        continue;
      end
      if (mif.sdr_rdy != '0) begin
        check("rdy_onehot", 64'($countones(mif.sdr_rdy)), 64'd1);
        seen_rdy = seen_rdy | mif.sdr_rdy;
      end
      for (int p = 0; p < NP; p++) begin
        if (mif.sdr_rdy[p]) begin
          if (exp_q.size() == 0) begin
            check("unexpected_rdy_port", 64'(p), 64'hFF);
          end else begin
            e = exp_q.pop_front();
            check("rdy_port", 64'(p), 64'(e[33:32]));
            check("rdy_data", 64'(mif.sdr_data[p*32 +: 32]), 64'(e[31:0]));
          end
        end
      end
      if (mif.mem_req && !prev_req) begin
        if (exp_issue_q.size() == 0) begin
          check("unexpected_issue", 64'(mif.mem_addr), 64'h3FF_FFFF_FFFF);
        end else begin
          ea = exp_issue_q.pop_front();
          check("issue_addr", 64'(mif.mem_addr), 64'(ea));
        end
        check("busy_on_issue", 64'(busy), 64'd1);
      end
      prev_req = mif.mem_req;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #3;
  endtask

  task automatic set_req(input int p, input logic [AW-1:0] a);
    mif.sdr_req[p] = 1'b1;
    mif.sdr_addr[p*AW +: AW] = a;
  endtask

  task automatic clr_req();
    mif.sdr_req = '0;
  endtask

  task automatic expect_fetch(input int p, input logic [AW-1:0] a, input logic [31:0] d);
    exp_issue_q.push_back(a);
    exp_q.push_back({2'(p), d});
  endtask

  task automatic wait_drain(input string name);
    int n;
    n = 0;
    while ((exp_q.size() != 0 || exp_issue_q.size() != 0 || mif.mem_req) && n < 200) begin
      tick();
      n++;
    end
    check(name, 64'(n < 200), 64'd1);
    tick();
    tick();
  endtask

  task automatic do_reset();
    clr_req();
    reset_n = 1'b0;
    tick();
    tick();
    reset_n = 1'b1;
    tick();
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    int            port;
    logic [AW-1:0] addr;
    int            delay;
    logic [31:0]   data;
    logic [NP-1:0] exp_rdy;
  } vec_t;

  vec_t vecs[6];

  // ---------------- main sequence ----------------
  initial begin
    int n;
    vecs[0] = '{port: 0, addr: 22'h000000, delay: 0, data: 32'h0000_0000, exp_rdy: 3'b001};
    vecs[1] = '{port: 1, addr: 22'h3FFFFF, delay: 1, data: 32'hFFFF_FFFF, exp_rdy: 3'b010};
    vecs[2] = '{port: 2, addr: 22'h2AAAAA, delay: 7, data: 32'h1234_5678, exp_rdy: 3'b100};
    vecs[3] = '{port: 0, addr: 22'h155555, delay: 3, data: 32'hA5A5_5A5A, exp_rdy: 3'b001};
    vecs[4] = '{port: 2, addr: 22'h000001, delay: 2, data: 32'h8000_0001, exp_rdy: 3'b100};
    vecs[5] = '{port: 1, addr: 22'h200000, delay: 0, data: 32'h0F0F_F0F0, exp_rdy: 3'b010};

    reset_n      = 1'b0;
    mif.sdr_req  = '0;
    mif.sdr_addr = '0;
    #1;
    check("reset_mem_req", 64'(mif.mem_req), 64'd0);
    check("reset_mem_addr", 64'(mif.mem_addr), 64'd0);
    check("reset_sdr_data", 64'(mif.sdr_data[63:0]), 64'd0);
    check("reset_sdr_rdy", 64'(mif.sdr_rdy), 64'd0);
    check("reset_busy", 64'(busy), 64'd0);
    check("reset_state", 64'(dbg_state), 64'd0);
    tick();
    tick();
    reset_n = 1'b1;
    tick();

    // 1. single fetch with latency checks
    ack_delay = 5;
    rsp_q.push_back(32'hDEADBEEF);
    expect_fetch(0, 22'h012344, 32'hDEADBEEF);
    set_req(0, 22'h012344);
    tick();
    clr_req();
    check("t1_no_req_yet", 64'(mif.mem_req), 64'd0);
    check("t1_pend", 64'(dbg_pend), 64'b001);
    tick();
    check("t1_mem_req", 64'(mif.mem_req), 64'd1);
    check("t1_mem_addr", 64'(mif.mem_addr), 64'h012344);
    n = 0;
    while (!mif.mem_ack && n < 50) begin
      tick();
      n++;
    end
    check("t1_ack_seen", 64'(mif.mem_ack), 64'd1);
    tick();
    check("t1_rdy", 64'(mif.sdr_rdy), 64'b001);
    check("t1_data", 64'(mif.sdr_data[31:0]), 64'hDEADBEEF);
    check("t1_mem_req_low", 64'(mif.mem_req), 64'd0);
    tick();
    check("t1_rdy_gone", 64'(mif.sdr_rdy), 64'b000);
    wait_drain("t1_drain");

    // table-driven single fetches
    for (int i = 0; i < 6; i++) begin
      ack_delay = vecs[i].delay;
      rsp_q.push_back(vecs[i].data);
      expect_fetch(vecs[i].port, vecs[i].addr, vecs[i].data);
      seen_rdy = '0;
      set_req(vecs[i].port, vecs[i].addr);
      tick();
      clr_req();
      wait_drain("vec_drain");
      check("vec_rdy_mask", 64'(seen_rdy), 64'(vecs[i].exp_rdy));
      check("vec_data", 64'(mif.sdr_data[vecs[i].port*32 +: 32]), 64'(vecs[i].data));
    end

    // 2. round-robin, from a fresh reset
    do_reset();
    ack_delay = 0;
    for (int r = 0; r < 2; r++) begin
      for (int p = 0; p < NP; p++) begin
        expect_fetch(p, AW'((p + 1) * 'h100 + r), mem_fn(AW'((p + 1) * 'h100 + r)));
        set_req(p, AW'((p + 1) * 'h100 + r));
      end
      tick();
      clr_req();
      wait_drain("t2_drain");
    end
    // port1 alone moves the pointer to 2, so the next triple runs 2,0,1
    expect_fetch(1, 22'h0002F0, mem_fn(22'h0002F0));
    set_req(1, 22'h0002F0);
    tick();
    clr_req();
    wait_drain("t2_single_drain");
    expect_fetch(2, 22'h000302, mem_fn(22'h000302));
    expect_fetch(0, 22'h000102, mem_fn(22'h000102));
    expect_fetch(1, 22'h000202, mem_fn(22'h000202));
    for (int p = 0; p < NP; p++) begin
      set_req(p, AW'((p + 1) * 'h100 + 2));
    end
    tick();
    clr_req();
    wait_drain("t2_rr_drain");

    // 3. supersede in flight
    ack_delay = 3;
    rsp_q.push_back(32'h0000_0011);
    rsp_q.push_back(32'h0000_0022);
    exp_issue_q.push_back(22'h000500);
    expect_fetch(1, 22'h000600, 32'h0000_0022);
    set_req(1, 22'h000500);
    tick();
    clr_req();
    tick();
    check("t3_in_flight", 64'(mif.mem_req), 64'd1);
    set_req(1, 22'h000600);
    tick();
    clr_req();
    wait_drain("t3_drain");
    check("t3_data", 64'(mif.sdr_data[63:32]), 64'h22);

    // 4. overwrite while pending
    ack_delay = 4;
    expect_fetch(0, 22'h000800, mem_fn(22'h000800));
    expect_fetch(2, 22'h000701, mem_fn(22'h000701));
    set_req(0, 22'h000800);
    tick();
    clr_req();
    tick();
    set_req(2, 22'h000700);
    tick();
    set_req(2, 22'h000701);
    tick();
    clr_req();
    wait_drain("t4_drain");

    // same-edge: request on the grant edge
    ack_delay = 2;
    exp_issue_q.push_back(22'h000A00);
    expect_fetch(1, 22'h000A01, mem_fn(22'h000A01));
    set_req(1, 22'h000A00);
    tick();
    set_req(1, 22'h000A01);
    tick();
    clr_req();
    wait_drain("grant_edge_drain");

    // same-edge: request on the ack edge
    ack_delay = 0;
    exp_issue_q.push_back(22'h000B00);
    expect_fetch(0, 22'h000B01, mem_fn(22'h000B01));
    set_req(0, 22'h000B00);
    tick();
    clr_req();
    tick();
    check("ack_edge_in_flight", 64'(mif.mem_ack), 64'd1);
    set_req(0, 22'h000B01);
    tick();
    clr_req();
    wait_drain("ack_edge_drain");

    // 5. reset mid-ISSUE
    ack_delay = 20;
    exp_issue_q.push_back(22'h000C00);
    set_req(0, 22'h000C00);
    tick();
    clr_req();
    tick();
    check("t5_in_flight", 64'(mif.mem_req), 64'd1);
    set_req(1, 22'h000C10);
    tick();
    clr_req();
    reset_n = 1'b0;
    #1;
    check("t5_mem_req_async", 64'(mif.mem_req), 64'd0);
    check("t5_busy_async", 64'(busy), 64'd0);
    check("t5_rdy_async", 64'(mif.sdr_rdy), 64'd0);
    check("t5_data_cleared", 64'(mif.sdr_data[63:0]), 64'd0);
    tick();
    reset_n = 1'b1;
    for (int i = 0; i < 8; i++) begin
      tick();
    end
    check("t5_no_issue_after", 64'(mif.mem_req), 64'd0);
    check("t5_no_pend", 64'(dbg_pend), 64'd0);
    ack_delay = 1;
    expect_fetch(2, 22'h000C20, mem_fn(22'h000C20));
    set_req(2, 22'h000C20);
    tick();
    clr_req();
    wait_drain("t5_new_req_drain");

    // 6. stray ack while idle
    seen_rdy = '0;
    stray_ack = 1'b1;
    tick();
    check("t6_ack_driven", 64'(mif.mem_ack), 64'd1);
    tick();
    tick();
    check("t6_no_rdy", 64'(seen_rdy), 64'd0);
    check("t6_state", 64'(dbg_state), 64'd0);
    check("t6_busy", 64'(busy), 64'd0);
    check("t6_data_kept", 64'(mif.sdr_data[95:64]), 64'(mem_fn(22'h000C20)));

    check("queues_empty", 64'(exp_q.size() + exp_issue_q.size()), 64'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
